// File: rtl/display_scan_mux.sv
// rtl/display_scan_mux.sv - time-multiplexed 7-segment scan driver with status override and blink
module display_scan_mux #(
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [4*DIGITS-1:0]   entrada,
    input  logic [3:0]            estado,
    input  logic                  atualiza,
    input  logic                  apaga_zeros,
    output logic [6:0]            segmentos,
    output logic [DIGITS-1:0]     anodos,
    output logic [2:0]            digito_ativo
);

    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV);

    localparam logic [3:0] EST_TOTAL   = 4'b0110;
    localparam logic [3:0] EST_PARCIAL = 4'b1101;
    localparam logic [3:0] EST_FALHA   = 4'b1110;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_S     = 7'b0100100;
    localparam logic [6:0] SEG_P     = 7'b0011000;
    localparam logic [6:0] SEG_F     = 7'b0111000;

    logic [4*DIGITS-1:0] shadow_dig;
    logic [3:0]          shadow_est;
    logic [SCAN_W-1:0]   scan_cnt;
    logic [BLINK_W-1:0]  blink_cnt;
    logic                phase_on;
    logic [2:0]          idx;

    logic [3:0]          cur_val;
    logic                above_zero;
    logic                blank_lz;
    logic                is_last;
    logic [6:0]          seg_next;
    logic [DIGITS-1:0]   an_next;

    function automatic logic [6:0] digit_pattern(input logic [3:0] v);
        case (v)
            4'd0:    digit_pattern = 7'b0000001;
            4'd1:    digit_pattern = 7'b1001111;
            4'd2:    digit_pattern = 7'b0010010;
            4'd3:    digit_pattern = 7'b0000110;
            4'd4:    digit_pattern = 7'b1001100;
            4'd5:    digit_pattern = 7'b0100100;
            4'd6:    digit_pattern = 7'b0100000;
            4'd7:    digit_pattern = 7'b0001111;
            4'd8:    digit_pattern = 7'b0000000;
            4'd9:    digit_pattern = 7'b0000100;
            default: digit_pattern = 7'b1111110;
        endcase
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shadow_dig <= '0;
            shadow_est <= 4'b0000;
        end else if (atualiza) begin
            shadow_dig <= entrada;
            shadow_est <= estado;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scan_cnt <= '0;
            idx      <= 3'd0;
        end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            idx      <= (idx == 3'(DIGITS - 1)) ? 3'd0 : idx + 3'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Counter and phase are pinned while not in falha so every entry starts lit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt <= '0;
            phase_on  <= 1'b1;
        end else if (shadow_est != EST_FALHA) begin
            blink_cnt <= '0;
            phase_on  <= 1'b1;
        end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            phase_on  <= ~phase_on;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    always_comb begin
        cur_val    = 4'd0;
        above_zero = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (3'(k) == idx)
                cur_val = shadow_dig[4*k +: 4];
            if (3'(k) > idx && shadow_dig[4*k +: 4] != 4'd0)
                above_zero = 1'b0;
        end
        blank_lz = apaga_zeros && (idx != 3'd0) && (cur_val == 4'd0) && above_zero;
        is_last  = (idx == 3'(DIGITS - 1));
    end

    always_comb begin
        seg_next = SEG_BLANK;
        case (shadow_est)
            EST_TOTAL:   seg_next = is_last ? SEG_S : SEG_BLANK;
            EST_PARCIAL: seg_next = is_last ? SEG_P : SEG_BLANK;
            EST_FALHA:   seg_next = (is_last && phase_on) ? SEG_F : SEG_BLANK;
            default:     seg_next = blank_lz ? SEG_BLANK : digit_pattern(cur_val);
        endcase
        an_next = ~(DIGITS'(1) << idx);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            segmentos    <= SEG_BLANK;
            anodos       <= '1;
            digito_ativo <= 3'd0;
        end else begin
            segmentos    <= seg_next;
            anodos       <= an_next;
            digito_ativo <= idx;
        end
    end

endmodule

// File: tb/tb_display_scan_mux.sv
// tb/tb_display_scan_mux.sv - scoreboard bench for display_scan_mux with a cycle-count reference model
module tb_display_scan_mux;

    localparam int DIGITS = 4;
    localparam int SCAN   = 4;
    localparam int BLINK  = 8;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] entrada = 16'h0;
    logic [3:0]  estado = 4'h0;
    logic        atualiza = 1'b0;
    logic        apaga_zeros = 1'b0;
    logic [6:0]  segmentos;
    logic [3:0]  anodos;
    logic [2:0]  digito_ativo;

    display_scan_mux #(.DIGITS(DIGITS), .SCAN_DIV(SCAN), .BLINK_DIV(BLINK)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .entrada(entrada),
        .estado(estado),
        .atualiza(atualiza),
        .apaga_zeros(apaga_zeros),
        .segmentos(segmentos),
        .anodos(anodos),
        .digito_ativo(digito_ativo)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: position in time since reset release decides slot and blink phase.
    logic [6:0]  pat_tab [16];
    logic [13:0] sb_q [$];
    int          t;
    int          sh_dig [DIGITS];
    int          sh_est;
    int          falha_since;
    int          m_slot;
    logic [6:0]  m_seg;
    logic [3:0]  m_an;

    initial begin
        pat_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                    7'b0000000, 7'b0000100, 7'b1111110, 7'b1111110,
                    7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110};
    end

    function automatic logic [6:0] model_seg(input int slot);
        int top;
        bit off;
        top = -1;
        for (int k = 0; k < DIGITS; k++)
            if (sh_dig[k] != 0) top = k;
        case (sh_est)
            6:  return (slot == DIGITS - 1) ? 7'b0100100 : 7'b1111111;
            13: return (slot == DIGITS - 1) ? 7'b0011000 : 7'b1111111;
            14: begin
                off = (((t - falha_since - 1) / BLINK) % 2) == 1;
                return (!off && slot == DIGITS - 1) ? 7'b0111000 : 7'b1111111;
            end
            default: begin
                if (apaga_zeros && slot != 0 && slot > top) return 7'b1111111;
                return pat_tab[sh_dig[slot]];
            end
        endcase
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            t = 0;
            for (int k = 0; k < DIGITS; k++) sh_dig[k] = 0;
            sh_est = 0;
            falha_since = 0;
            sb_q.delete();
        end else begin
            m_slot = (t / SCAN) % DIGITS;
            m_seg  = model_seg(m_slot);
            m_an   = 4'(~(1 << m_slot));
            sb_q.push_back({m_seg, m_an, 3'(m_slot)});
            if (atualiza) begin
                if (estado == 4'd14 && sh_est != 14) falha_since = t;
                sh_est = int'(estado);
                for (int k = 0; k < DIGITS; k++)
                    sh_dig[k] = int'((entrada >> (4 * k)) & 16'hF);
            end
            t++;
        end
    end

    always @(negedge clock) begin
        logic [13:0] e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("segmentos", int'(segmentos), int'(e[13:7]));
            check("anodos", int'(anodos), int'(e[6:3]));
            check("digito_ativo", int'(digito_ativo), int'(e[2:0]));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic load(input logic [15:0] d, input logic [3:0] e);
        entrada  = d;
        estado   = e;
        atualiza = 1'b1;
        step(1);
        atualiza = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_seg"}, int'(segmentos), 'h7f);
        check({tag, "_an"}, int'(anodos), 'hf);
        check({tag, "_idx"}, int'(digito_ativo), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit found;
        int r;
        step(3);
        check_reset_outputs("reset_hold");
        reset_n = 1'b1;

        load(16'h1234, 4'h0);
        step(20);

        apaga_zeros = 1'b1;
        load(16'h0070, 4'h0);
        step(16);
        apaga_zeros = 1'b0;
        step(16);

        apaga_zeros = 1'b1;
        load(16'h00A5, 4'h0);
        step(16);

        load(16'h00A5, 4'hD);
        step(16);
        load(16'h00A5, 4'h6);
        step(16);

        load(16'h0000, 4'hE);
        step(40);
        load(16'h0000, 4'h0);
        load(16'h0000, 4'hE);
        step(20);

        load(16'h5678, 4'h0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (digito_ativo == 3'd2) found = 1'b1;
            else step(1);
        end
        check("reach_slot2", int'(found), 1);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        #1;
        reset_n = 1'b1;
        step(8);

        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 4);
            entrada     = 16'($urandom);
            apaga_zeros = 1'($urandom);
            atualiza    = ($urandom_range(0, 3) == 0);
            case (r)
                0: estado = 4'h6;
                1: estado = 4'hD;
                2: estado = 4'hE;
                default: estado = 4'($urandom);
            endcase
            step(1);
        end
        atualiza = 1'b0;
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
